mole_spawner: RTL and testbench
===============================

Name: mole_spawner

Overview:
- Produces the mole stimulus that the hammer block consumes: chooses a pseudo-random hole, shows the mole for a bounded time, and withdraws it on a hit or a timeout.
- Drives mole_position and mole_visible to the hammer and the display logic, and counts the moles that escaped (misses).
- Sits between the game controller (enable) and the hammer (hit feedback), in the same clk domain.

Parameters:
- NUM_HOLES, 18, number of valid holes; positions are 0..NUM_HOLES-1 (must be ≤ 32 and > 16).
- POS_W, 5, width of mole_position.
- UP_CYCLES, 50_000_000, cycles a mole stays visible if it is not hit (≥ 2).
- GAP_CYCLES, 12_500_000, cycles with no mole between spawns (≥ 2).
- CNT_W, 12, width of miss_count.
- SEED, 16'hACE1, LFSR reset value (must be non-zero).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- enable  in  1  game running; level-sensitive.
- hit  in  1  from hammer; 1 = the current mole was struck this cycle.
- mole_position  out  POS_W  current hole index.
- mole_visible  out  1  mole is up.
- spawn  out  1  one-cycle pulse when a new mole appears.
- miss_count  out  CNT_W  moles that timed out, saturating.

Behaviour:
- Reset (asynchronous, reset=0):
  - State = IDLE; mole_position = 0; mole_visible = 0; spawn = 0; miss_count = 0.
  - LFSR = SEED; timer = 0.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every cycle while not in reset, regardless of state, so the sequence depends on player timing.
- Candidate position:
  - c = lfsr[4:0]. If c ≥ NUM_HOLES, then c = c − NUM_HOLES; one subtraction suffices because 32 − NUM_HOLES < NUM_HOLES.
  - If c == mole_position, use c+1, wrapping NUM_HOLES−1 → 0.
  - A mole never respawns in the same hole twice in a row.
- FSM states: IDLE, GAP, UP. All outputs are registered.
- IDLE:
  - mole_visible = 0.
  - enable=1 → GAP, with timer = GAP_CYCLES−1.
- GAP:
  - Timer decrements each cycle.
  - At timer==0 → UP: mole_position ← candidate, mole_visible ← 1, spawn ← 1 for that one cycle, timer = UP_CYCLES−1.
- UP:
  - hit=1 → GAP next cycle: mole_visible ← 0, timer = GAP_CYCLES−1, miss_count unchanged.
  - Else at timer==0 → GAP: mole_visible ← 0, miss_count += 1, saturating at 2^CNT_W−1.
  - Else the timer decrements.
- Boundary conditions:
  - Hit and timeout in the same cycle: the hit wins and no miss is counted.
  - hit while in IDLE or GAP: ignored.
  - enable=0 in any state → IDLE next cycle. mole_visible drops, no miss is counted, and miss_count and mole_position are held.
  - miss_count clears only on reset.
  - Reset mid-UP: all outputs clear asynchronously. After reset releases, the first mole appears exactly GAP_CYCLES+1 cycles after enable is first sampled high.
- mole_position holds its value through GAP and IDLE and changes only on the GAP→UP transition.
- Visible window: a mole that is never hit is visible for exactly UP_CYCLES cycles.

Decomposition:
- Shared package (game_pkg):
  - State enum {IDLE, GAP, UP}.
  - NUM_HOLES, POS_W and CNT_W defaults, shared with hammer.
- Sub-module lfsr16 (parameter SEED, output value, free-running).
- The candidate reduction, timer and FSM stay in mole_spawner.

Test Plan:
- Bench parameters: UP_CYCLES=8, GAP_CYCLES=4.
- Reset then enable=1 at cycle 0:
  - spawn pulses at cycle 5, with mole_visible=1 in cycles 5..12.
  - mole_position is in 0..17.
  - With no hit: mole_visible=0 at cycle 13 and miss_count=1.
- hit=1 in the third visible cycle:
  - mole_visible=0 on the next cycle and miss_count is unchanged.
  - The next spawn comes exactly 4 cycles later.
- hit=1 on the last visible cycle (timer==0): the mole is removed and miss_count does not increment.
- Run 1000 spawns with hits at random times:
  - Every mole_position < 18.
  - No two consecutive spawns share a position.
  - spawn is never wider than 1 cycle.
- Pull reset=0 while a mole is up:
  - mole_visible, miss_count and mole_position go to 0 immediately.
  - After release with enable held, a spawn comes 5 cycles later.
- Force miss_count to 4094 (CNT_W=12) and let 3 moles time out: the count ends at 4095 and stays there.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: mole FSM state encoding and the field-size defaults
// that the spawner and the hammer must agree on.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    UP   = 2'd2
  } state_e;

  localparam int NUM_HOLES_DEF = 18;
  localparam int POS_W_DEF     = 5;
  localparam int CNT_W_DEF     = 12;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11); never stalls, so the
// value seen at spawn time depends on how long the player took.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_ni,
  output logic [15:0] value_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        feedback;

  assign feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr_d   = {lfsr_q[14:0], feedback};

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/mole_spawner.sv
// Mole spawner: picks a pseudo-random hole, shows the mole for a bounded time,
// withdraws it on hit or timeout, and counts escaped moles (saturating).
module mole_spawner
  import game_pkg::*;
#(
  parameter int          NUM_HOLES  = NUM_HOLES_DEF,
  parameter int          POS_W      = POS_W_DEF,
  parameter int          UP_CYCLES  = 50_000_000,
  parameter int          GAP_CYCLES = 12_500_000,
  parameter int          CNT_W      = CNT_W_DEF,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             hit,
  output logic [POS_W-1:0] mole_position,
  output logic             mole_visible,
  output logic             spawn,
  output logic [CNT_W-1:0] miss_count
);

  localparam int TMR_MAX = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] UP_LOAD   = TMR_W'(UP_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [5:0]       NH        = 6'(NUM_HOLES);
  localparam logic [5:0]       LAST_HOLE = 6'(NUM_HOLES - 1);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               vis_q, vis_d;
  logic               spawn_q, spawn_d;
  logic [CNT_W-1:0]   miss_q, miss_d;

  logic [15:0]        lfsr_value;
  logic               lfsr_unused;
  logic [5:0]         c_raw, c_red, c_fin;
  logic [POS_W-1:0]   cand;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst_ni  (reset),
    .value_o (lfsr_value)
  );

  assign lfsr_unused = ^lfsr_value[15:5];

  // Fold 0..31 into 0..NUM_HOLES-1 with one subtraction, then step off the current hole.
  always_comb begin
    c_raw = {1'b0, lfsr_value[4:0]};
    c_red = (c_raw >= NH) ? (c_raw - NH) : c_raw;
    c_fin = c_red;
    if (POS_W'(c_red) == pos_q) begin
      c_fin = (c_red == LAST_HOLE) ? 6'd0 : (c_red + 6'd1);
    end
    cand = POS_W'(c_fin);
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pos_d   = pos_q;
    vis_d   = vis_q;
    spawn_d = 1'b0;
    miss_d  = miss_q;
    if (!enable) begin
      state_d = IDLE;
      vis_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = GAP;
          timer_d = GAP_LOAD;
          vis_d   = 1'b0;
        end
        GAP: begin
          if (timer_q == '0) begin
            state_d = UP;
            timer_d = UP_LOAD;
            pos_d   = cand;
            vis_d   = 1'b1;
            spawn_d = 1'b1;
          end else begin
            timer_d = timer_q - TMR_W'(1);
          end
        end
        UP: begin
          // A hit takes priority over a simultaneous timeout.
          if (hit) begin
            state_d = GAP;
            timer_d = GAP_LOAD;
            vis_d   = 1'b0;
          end else if (timer_q == '0) begin
            state_d = GAP;
            timer_d = GAP_LOAD;
            vis_d   = 1'b0;
            if (miss_q != '1) begin
              miss_d = miss_q + CNT_W'(1);
            end
          end else begin
            timer_d = timer_q - TMR_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          vis_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      pos_q   <= '0;
      vis_q   <= 1'b0;
      spawn_q <= 1'b0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pos_q   <= pos_d;
      vis_q   <= vis_d;
      spawn_q <= spawn_d;
      miss_q  <= miss_d;
    end
  end

  assign mole_position = pos_q;
  assign mole_visible  = vis_q;
  assign spawn         = spawn_q;
  assign miss_count    = miss_q;

endmodule

// File: tb/tb_mole_spawner.sv
// Directed bench for mole_spawner with UP_CYCLES=8, GAP_CYCLES=4.
module tb_mole_spawner;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        hit;
  logic [4:0]  mole_position;
  logic        mole_visible;
  logic        spawn;
  logic [11:0] miss_count;

  int          checks   = 0;
  int          failures = 0;
  int          exp_miss = 0;
  logic [4:0]  last_pos = '0;

  always #5 clk = ~clk;

  mole_spawner #(
    .NUM_HOLES  (18),
    .POS_W      (5),
    .UP_CYCLES  (8),
    .GAP_CYCLES (4),
    .CNT_W      (12),
    .SEED       (16'hACE1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .hit           (hit),
    .mole_position (mole_position),
    .mole_visible  (mole_visible),
    .spawn         (spawn),
    .miss_count    (miss_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until spawn is seen (current cycle included); ok=0 if the budget runs out.
  task automatic wait_spawn(output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    for (int k = 0; k < 64; k++) begin
      if (spawn === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
      waited++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; hit = 1'b0;
    #12;
    checks++; if (mole_visible !== 1'b0) begin failures++; $display("FAIL reset_visible got=%b want=0", mole_visible); end
    checks++; if (spawn !== 1'b0) begin failures++; $display("FAIL reset_spawn got=%b want=0", spawn); end
    checks++; if (mole_position !== 5'd0) begin failures++; $display("FAIL reset_pos got=%0d want=0", mole_position); end
    checks++; if (miss_count !== 12'd0) begin failures++; $display("FAIL reset_miss got=%0d want=0", miss_count); end
    step();
    reset = 1'b1;
    step();
    step();
    checks++; if (mole_visible !== 1'b0) begin failures++; $display("FAIL idle_visible got=%b want=0", mole_visible); end
    $display("reset: outputs cleared, idle with enable low");
  endtask

  task automatic test_first_spawn();
    bit exp_vis, exp_sp;
    enable = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      step();
      exp_sp  = (c == 5);
      exp_vis = (c >= 5 && c <= 12);
      checks++; if (spawn !== exp_sp) begin failures++; $display("FAIL first_spawn cycle=%0d got=%b want=%b", c, spawn, exp_sp); end
      checks++; if (mole_visible !== exp_vis) begin failures++; $display("FAIL first_visible cycle=%0d got=%b want=%b", c, mole_visible, exp_vis); end
      if (c == 5) begin
        checks++; if (mole_position >= 5'd18) begin failures++; $display("FAIL first_pos got=%0d want<18", mole_position); end
        last_pos = mole_position;
      end
    end
    exp_miss = 1;
    checks++; if (miss_count !== 12'd1) begin failures++; $display("FAIL first_timeout_miss got=%0d want=1", miss_count); end
    $display("first spawn: pos=%0d miss=%0d", last_pos, miss_count);
  endtask

  task automatic test_hit_early();
    bit ok; int w; int gap;
    wait_spawn(ok, w);
    checks++; if (!ok) begin failures++; $display("FAIL hit_early_wait got=timeout want=spawn"); end
    checks++; if (mole_position === last_pos) begin failures++; $display("FAIL hit_early_repeat got=%0d want!=%0d", mole_position, last_pos); end
    last_pos = mole_position;
    step(); step();
    hit = 1'b1;
    step();
    hit = 1'b0;
    checks++; if (mole_visible !== 1'b0) begin failures++; $display("FAIL hit_early_visible got=%b want=0", mole_visible); end
    checks++; if (miss_count !== 12'(exp_miss)) begin failures++; $display("FAIL hit_early_miss got=%0d want=%0d", miss_count, exp_miss); end
    gap = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (spawn === 1'b1) begin gap = k; break; end
    end
    checks++; if (gap != 4) begin failures++; $display("FAIL hit_early_gap got=%0d want=4", gap); end
    $display("hit early: pos=%0d next spawn after %0d cycles", last_pos, gap);
  endtask

  task automatic test_hit_last();
    bit ok; int w;
    wait_spawn(ok, w);
    checks++; if (!ok) begin failures++; $display("FAIL hit_last_wait got=timeout want=spawn"); end
    last_pos = mole_position;
    for (int k = 0; k < 7; k++) step();
    checks++; if (mole_visible !== 1'b1) begin failures++; $display("FAIL hit_last_still_up got=%b want=1", mole_visible); end
    hit = 1'b1;
    step();
    hit = 1'b0;
    checks++; if (mole_visible !== 1'b0) begin failures++; $display("FAIL hit_last_visible got=%b want=0", mole_visible); end
    checks++; if (miss_count !== 12'(exp_miss)) begin failures++; $display("FAIL hit_last_miss got=%0d want=%0d", miss_count, exp_miss); end
    $display("hit on last visible cycle: miss=%0d", miss_count);
  endtask

  task automatic test_disable();
    bit ok; int w; int gap;
    wait_spawn(ok, w);
    checks++; if (!ok) begin failures++; $display("FAIL disable_wait got=timeout want=spawn"); end
    last_pos = mole_position;
    step();
    enable = 1'b0;
    step();
    checks++; if (mole_visible !== 1'b0) begin failures++; $display("FAIL disable_visible got=%b want=0", mole_visible); end
    checks++; if (mole_position !== last_pos) begin failures++; $display("FAIL disable_pos got=%0d want=%0d", mole_position, last_pos); end
    checks++; if (miss_count !== 12'(exp_miss)) begin failures++; $display("FAIL disable_miss got=%0d want=%0d", miss_count, exp_miss); end
    for (int k = 0; k < 12; k++) step();
    checks++; if (mole_visible !== 1'b0 || spawn !== 1'b0) begin failures++; $display("FAIL disable_idle got=%b%b want=00", mole_visible, spawn); end
    enable = 1'b1;
    gap = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (spawn === 1'b1) begin gap = k; break; end
    end
    checks++; if (gap != 5) begin failures++; $display("FAIL reenable_gap got=%0d want=5", gap); end
    checks++; if (mole_position === last_pos) begin failures++; $display("FAIL reenable_repeat got=%0d want!=%0d", mole_position, last_pos); end
    last_pos = mole_position;
    $display("disable/re-enable: spawn after %0d cycles pos=%0d", gap, last_pos);
    for (int k = 0; k < 8; k++) step();
    exp_miss++;
  endtask

  task automatic test_random();
    bit ok; int w; int hit_at;
    for (int n = 0; n < 1000; n++) begin
      wait_spawn(ok, w);
      checks++; if (!ok) begin failures++; $display("FAIL random_wait n=%0d got=timeout want=spawn", n); break; end
      checks++; if (mole_position >= 5'd18) begin failures++; $display("FAIL random_range n=%0d got=%0d want<18", n, mole_position); end
      checks++; if (mole_position === last_pos) begin failures++; $display("FAIL random_repeat n=%0d got=%0d want!=%0d", n, mole_position, last_pos); end
      last_pos = mole_position;
      hit_at = $urandom_range(0, 8);
      for (int v = 1; v <= 8; v++) begin
        if (v == hit_at) hit = 1'b1;
        step();
        hit = 1'b0;
        if (v == 1) begin
          checks++; if (spawn !== 1'b0) begin failures++; $display("FAIL random_spawn_width n=%0d got=%b want=0", n, spawn); end
        end
        if (v == hit_at) break;
      end
      if (hit_at == 0) exp_miss++;
      checks++; if (mole_visible !== 1'b0) begin failures++; $display("FAIL random_down n=%0d got=%b want=0", n, mole_visible); end
      checks++; if (miss_count !== 12'(exp_miss)) begin failures++; $display("FAIL random_miss n=%0d got=%0d want=%0d", n, miss_count, exp_miss); end
      $display("spawn %0d: pos=%0d hit_at=%0d miss=%0d", n, last_pos, hit_at, miss_count);
    end
  endtask

  task automatic test_reset_mid_up();
    bit ok; int w; int gap;
    wait_spawn(ok, w);
    checks++; if (!ok) begin failures++; $display("FAIL rst_mid_wait got=timeout want=spawn"); end
    step(); step();
    reset = 1'b0;
    #1;
    checks++; if (mole_visible !== 1'b0) begin failures++; $display("FAIL rst_mid_visible got=%b want=0", mole_visible); end
    checks++; if (miss_count !== 12'd0) begin failures++; $display("FAIL rst_mid_miss got=%0d want=0", miss_count); end
    checks++; if (mole_position !== 5'd0) begin failures++; $display("FAIL rst_mid_pos got=%0d want=0", mole_position); end
    #1;
    reset = 1'b1;
    exp_miss = 0;
    last_pos = '0;
    gap = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (spawn === 1'b1) begin gap = k; break; end
    end
    checks++; if (gap != 5) begin failures++; $display("FAIL rst_mid_gap got=%0d want=5", gap); end
    $display("reset mid-up: spawn %0d cycles after release", gap);
  endtask

  task automatic test_saturation();
    bit ok; int w;
    for (int n = 0; n < 4097; n++) begin
      wait_spawn(ok, w);
      checks++; if (!ok) begin failures++; $display("FAIL sat_wait n=%0d got=timeout want=spawn", n); break; end
      for (int v = 0; v < 8; v++) step();
      if (exp_miss < 4095) exp_miss++;
      checks++; if (miss_count !== 12'(exp_miss)) begin failures++; $display("FAIL sat_miss n=%0d got=%0d want=%0d", n, miss_count, exp_miss); end
      if (exp_miss >= 4094) $display("timeout %0d: miss=%0d", n, miss_count);
    end
  endtask

  initial begin
    test_reset();
    test_first_spawn();
    test_hit_early();
    test_hit_last();
    test_disable();
    test_random();
    test_reset_mid_up();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
